// File: rtl/riscv_alu_pkg.sv
// Shared encodings for the execute-stage arithmetic units.
// Contents: funct[1:0] codes for DIV/DIVU/REM/REMU, divider FSM states and small decode helpers.
// No logic. Every divider file imports this package.
package riscv_alu_pkg;

    localparam logic [1:0] FN_DIV  = 2'b00;
    localparam logic [1:0] FN_DIVU = 2'b01;
    localparam logic [1:0] FN_REM  = 2'b10;
    localparam logic [1:0] FN_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CALC = 2'd2,
        FIN  = 2'd3
    } state_t;

    function automatic logic fn_is_signed(input logic [1:0] fn);
        return (fn == FN_DIV) || (fn == FN_REM);
    endfunction

    function automatic logic fn_is_rem(input logic [1:0] fn);
        return (fn == FN_REM) || (fn == FN_REMU);
    endfunction

endpackage

// File: rtl/div32_seq_if.sv
// Request/response bundle between the execute stage and the sequential divider.
// Signals: start, funct, srca and srcb (requester to divider); busy, done and result (divider to requester).
// The master modport is the requester side and the slave modport is the divider side.
interface div32_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       funct;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, funct, srca, srcb,
        input  busy, done, result
    );

    modport slave (
        input  start, funct, srca, srcb,
        output busy, done, result
    );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
// Inputs: rem, quo and divisor. Outputs: rem_next and quo_next. There are no registers.
// The dividend bits are fed in from the quo MSB, and quo_next collects the quotient bits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH:0]   part;
    logic [WIDTH+1:0] sum;
    logic [WIDTH:0]   sel;
    logic             ge;
    logic             unused_sel_msb;

    // The partial remainder is WIDTH+1 bits wide because the shifted-in bit can push it past 2^WIDTH.
    assign part = {rem, quo[WIDTH-1]};

    // part - divisor is computed as part + ~divisor + 1 in WIDTH+2 bits.
    // The carry out is 1 exactly when there is no borrow, which means part >= divisor.
    assign sum = {1'b0, part} + {1'b0, ~{1'b0, divisor}} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign ge  = sum[WIDTH+1];

    assign sel      = ge ? sum[WIDTH:0] : part;
    // The restored remainder is always below the divisor, so the top bit is always zero.
    assign rem_next = sel[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ge};

    assign unused_sel_msb = sel[WIDTH];
endmodule

// File: rtl/div32_seq.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Ports: clk and reset (synchronous, active-high). The bus (slave) carries start, funct, srca, srcb, busy, done and result.
// Latency is start+WIDTH+2. With DIV_EARLY_OUT_EN defined, divide-by-zero and signed overflow finish at start+2. A start seen while busy is dropped.
module div32_seq
    import riscv_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    div32_seq_if.slave  bus
);
    localparam int               CW      = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef DIV_EARLY_OUT_EN
    localparam logic EARLY_OUT = 1'b1;
`else
    localparam logic EARLY_OUT = 1'b0;
`endif

    state_t           state, state_n;
    logic [1:0]       fn_q;
    logic [WIDTH-1:0] a_q, b_q, rem_q, quo_q, result_q;
    logic [CW-1:0]    cnt_q;
    logic             qneg_q, rneg_q;

    logic             sgn, sa, sb, div_zero, ovf, early, last_iter;
    logic [WIDTH-1:0] a_abs, b_abs, rem_step, quo_step, quo_fix, rem_fix, fin_val;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (b_q),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    // Operand conditioning runs in PREP on the operands captured when start was accepted.
    // The abs of MIN_NEG wraps back to MIN_NEG, and that value is correct when read as unsigned.
    assign sgn      = fn_is_signed(fn_q);
    assign sa       = sgn & a_q[WIDTH-1];
    assign sb       = sgn & b_q[WIDTH-1];
    assign a_abs    = sa ? (~a_q + ONE) : a_q;
    assign b_abs    = sb ? (~b_q + ONE) : b_q;
    assign div_zero = (b_q == '0);
    assign ovf      = sgn && (a_q == MIN_NEG) && (b_q == '1);
    assign early    = EARLY_OUT & (div_zero | ovf);
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // Sign fix-up. A zero divisor already gives an all-ones quotient and must not be negated, so qneg is cleared for that case.
    assign quo_fix = qneg_q ? (~quo_q + ONE) : quo_q;
    assign rem_fix = rneg_q ? (~rem_q + ONE) : rem_q;
    assign fin_val = fn_is_rem(fn_q) ? rem_fix : quo_fix;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = PREP;
            PREP:    state_n = early ? FIN : CALC;
            CALC:    if (last_iter) state_n = FIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fn_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        fn_q <= bus.funct;
                        a_q  <= bus.srca;
                        b_q  <= bus.srcb;
                    end
                end
                PREP: begin
                    b_q    <= b_abs;
                    qneg_q <= (sa ^ sb) & ~div_zero;
                    rneg_q <= sa;
                    cnt_q  <= '0;
                    if (early) begin
                        // Load the values the full iteration would have produced.
                        quo_q <= div_zero ? '1 : a_abs;
                        rem_q <= div_zero ? a_abs : '0;
                    end else begin
                        quo_q <= a_abs;
                        rem_q <= '0;
                    end
                end
                CALC: begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    cnt_q <= cnt_q + CW'(1);
                end
                FIN: begin
                    result_q <= fin_val;
                end
                default: ;
            endcase
        end
    end

    // During FIN the fixed-up value is passed straight through, so result is valid in the same cycle as done.
    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == FIN);
    assign bus.result = (state == FIN) ? fin_val : result_q;
endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq.
// A cycle-level reference (arithmetic result + latency window) is compared against busy/done/result every cycle,
// directed vectors pin literal results and latencies, and DIV_EARLY_OUT_EN is honoured if defined.
module tb_div32_seq;
    import riscv_alu_pkg::*;

`ifdef DIV_EARLY_OUT_EN
    localparam int LAT_SPECIAL = 2;
`else
    localparam int LAT_SPECIAL = 34;
`endif
    localparam int LAT_FULL = 34;

    logic clk = 1'b0;
    logic reset;

    div32_seq_if #(.WIDTH(32)) bus ();

    div32_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // RV32M semantics written straight from the instruction definitions.
    function automatic logic [31:0] ref_div(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (b == 32'd0) return (fn == FN_REM || fn == FN_REMU) ? a : 32'hFFFF_FFFF;
        case (fn)
            FN_DIVU: return a / b;
            FN_REMU: return a % b;
            FN_DIV:  return ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            default: return ovf ? 32'd0 : 32'($signed(a) % $signed(b));
        endcase
    endfunction

    function automatic int lat_of(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return LAT_SPECIAL;
        if ((fn == FN_DIV || fn == FN_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return LAT_SPECIAL;
        return LAT_FULL;
    endfunction

    // Reference: one accepted operation occupies cycles t+1..t+lat, and done is raised in the last of those cycles.
    int          cyc = 0;
    int          m_t = 0;
    int          m_lat = 0;
    bit          m_act = 1'b0;
    bit          m_valid = 1'b0;
    logic [31:0] m_exp = '0;
    logic [31:0] m_held = '0;

    function automatic bit m_busy_now();
        return m_act && (cyc >= m_t + 1) && (cyc <= m_t + m_lat);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_act   = 1'b0;
            m_held  = '0;
            m_valid = 1'b1;
        end else begin
            bit idle;
            idle = !m_busy_now();
            if (m_act && cyc == m_t + m_lat) m_held = m_exp;
            if (idle && bus.start) begin
                m_act = 1'b1;
                m_t   = cyc;
                m_exp = ref_div(bus.funct, bus.srca, bus.srcb);
                m_lat = lat_of(bus.funct, bus.srca, bus.srcb);
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            bit done_e;
            done_e = m_act && (cyc == m_t + m_lat);
            check("cyc_busy", {31'd0, bus.busy}, {31'd0, m_busy_now()});
            check("cyc_done", {31'd0, bus.done}, {31'd0, done_e});
            check("cyc_result", bus.result, done_e ? m_exp : m_held);
        end
    end

    task automatic run_op(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input string name);
        int lat;
        logic [31:0] res;
        lat = 0;
        res = 'x;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.funct = fn; bus.srca = a; bus.srcb = b;
        @(posedge clk); #1;
        // Change the inputs after the start cycle. They must have no effect on the operation in flight.
        bus.start = 1'b0; bus.funct = ~fn; bus.srca = ~a; bus.srcb = b + 32'd3;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k;
                res = bus.result;
                break;
            end
        end
        check({name, "_result"}, res, exp);
        check({name, "_latency"}, lat, exp_lat);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          ndone;
        int          lat;
        logic [31:0] res;
        logic [1:0]  fn;
        logic [31:0] a, b;

        reset = 1'b1;
        bus.start = 1'b0; bus.funct = 2'b00; bus.srca = '0; bus.srcb = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_result", bus.result, 32'd0);

        // Pin the reference model to hand-computed values.
        check("model_divu", ref_div(FN_DIVU, 32'd100, 32'd7), 32'd14);
        check("model_rem_neg", ref_div(FN_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        check("model_div_ovf", ref_div(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

        run_op(FN_DIVU, 32'd100, 32'd7, 32'd14, LAT_FULL, "divu_100_7");
        run_op(FN_REMU, 32'd100, 32'd7, 32'd2, LAT_FULL, "remu_100_7");
        run_op(FN_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_FULL, "div_m7_2");
        run_op(FN_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_FULL, "rem_m7_2");
        run_op(FN_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_FULL, "div_7_m2");
        run_op(FN_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, LAT_FULL, "rem_7_m2");
        run_op(FN_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SPECIAL, "div_5_0");
        run_op(FN_REM, 32'd5, 32'd0, 32'd5, LAT_SPECIAL, "rem_5_0");
        run_op(FN_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, LAT_SPECIAL, "div_m5_0");
        run_op(FN_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, LAT_SPECIAL, "rem_m5_0");
        run_op(FN_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SPECIAL, "divu_5_0");
        run_op(FN_REMU, 32'd5, 32'd0, 32'd5, LAT_SPECIAL, "remu_5_0");
        run_op(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPECIAL, "div_ovf");
        run_op(FN_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_SPECIAL, "rem_ovf");
        run_op(FN_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_FULL, "divu_min_max");
        run_op(FN_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_FULL, "remu_min_max");
        run_op(FN_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, LAT_FULL, "divu_max_1");

        // Handshake: a second start at T+5 is dropped and the first operation completes normally.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.funct = FN_DIVU; bus.srca = 32'd1000; bus.srcb = 32'd10;
        ndone = 0; lat = 0; res = 'x;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk); #1;
            bus.start = (k == 5);
            if (k == 5) begin
                bus.funct = FN_DIV; bus.srca = 32'd9; bus.srcb = 32'd3;
            end
            @(negedge clk);
            if (bus.done) begin
                ndone++; lat = k; res = bus.result;
            end
        end
        check("hs_done_count", ndone, 32'd1);
        check("hs_latency", lat, LAT_FULL);
        check("hs_result", res, 32'd100);

        // Reset asserted mid-CALC aborts the operation.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.funct = FN_DIVU; bus.srca = 32'h0000_FFFF; bus.srcb = 32'd3;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            reset = (k == 10);
            @(negedge clk);
            if (k == 11) begin
                check("abort_busy", {31'd0, bus.busy}, 32'd0);
                check("abort_done", {31'd0, bus.done}, 32'd0);
                check("abort_result", bus.result, 32'd0);
            end
        end
        run_op(FN_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, LAT_FULL, "post_abort_div");

        for (int i = 0; i < 400; i++) begin
            fn = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            run_op(fn, a, b, ref_div(fn, a, b), lat_of(fn, a, b), "rand");
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
